store_buffer_drain_ctrl: RTL
============================

STORE_BUFFER_DRAIN_CTRL -- requirements
Module: store_buffer_drain_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 32: store buffer entry count.
REQ-002 SHALL have parameter HIGH_WM, default 24: occupancy at which stores outrank loads.
REQ-003 SHALL have parameter STARVE_MAX, default 8: consecutive lost arbitrations before a store is forced.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state on rising edge.
  rst  in  1  asynchronous, active-high reset.
  i_sb_count  in  $clog2(CAPACITY+1)  committed entries in the store buffer.
  i_sb_head_valid  in  1  oldest committed entry is ready to evict.
  i_sb_head_addr  in  Address  head entry address.
  i_sb_head_data  in  Data  head entry data.
  o_sb_pop  out  1  one-cycle pulse that retires the head entry.
  i_load_req  in  1  load miss wants the D-cache write/fill port.
  o_load_grant  out  1  load owns the port this cycle.
  o_dc_wr_valid  out  1  store write request to D-cache.
  o_dc_wr_addr  out  Address  request address.
  o_dc_wr_data  out  Data  request data.
  i_dc_wr_ready  in  1  D-cache accepts the request.
  i_dc_wr_done  in  1  D-cache write complete.
  i_fence  in  1  one-cycle pulse requesting a full drain.
  o_fence_done  out  1  one-cycle pulse when a fence drain completes.
  o_stall_commit  out  1  stop commit from adding entries.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-006 SHALL define urgent = (i_sb_count >= HIGH_WM) or fence_active or (starve_cnt == STARVE_MAX).
REQ-007 IDLE: SHALL go to ISSUE when i_sb_head_valid and (not i_load_req or urgent), latching head addr/data.
REQ-008 SHALL assert o_load_grant combinationally iff i_load_req, state==IDLE, and not (i_sb_head_valid and urgent).
REQ-009 ISSUE: SHALL hold o_dc_wr_valid=1 with stable latched addr/data until i_dc_wr_ready, then go to WAIT.
REQ-010 WAIT: on i_dc_wr_done SHALL pulse o_sb_pop for exactly one cycle and return to IDLE; i_dc_wr_done SHALL be ignored outside WAIT.
REQ-011 Minimum store latency: ISSUE entered one cycle after the IDLE decision; pop no earlier than the cycle after ready.
REQ-012 starve_cnt SHALL increment, saturating at STARVE_MAX, each cycle in IDLE where i_sb_head_valid and o_load_grant; it SHALL clear on o_sb_pop.
REQ-013 i_fence SHALL set fence_active; if the buffer is already empty (IDLE, not i_sb_head_valid, i_sb_count==0), o_fence_done SHALL pulse the next cycle.
REQ-014 fence_active SHALL clear, and o_fence_done SHALL pulse one cycle later, when state==IDLE, i_sb_head_valid==0 and i_sb_count==0.
REQ-015 i_fence while fence_active SHALL be absorbed and produce no extra o_fence_done.
REQ-016 o_stall_commit SHALL be 1 iff i_sb_count >= CAPACITY-1 or fence_active.
REQ-017 o_dc_wr_valid and o_load_grant SHALL never both be 1.
REQ-018 Count widths SHALL be $clog2(CAPACITY+1) and $clog2(STARVE_MAX+1), unsigned; no wrap.

Reset
REQ-019 rst SHALL force IDLE, fence_active=0, starve_cnt=0, latched addr/data=0 immediately.
REQ-020 During and after reset, all outputs SHALL be 0 except o_load_grant, which follows REQ-008.
REQ-021 Reset during ISSUE/WAIT SHALL abandon the request without o_sb_pop; the entry stays in the buffer.

Structure
REQ-022 Address and Data SHALL come from mips_core_pkg; a drain_state_t enum SHALL be added there.
REQ-023 SHALL be a single module with no sub-modules; arbitration, FSM and fence logic live inline.

Verification
REQ-024 Count=1, head valid, no load -> ISSUE next cycle; ready at cycle 3, done at cycle 5 -> one o_sb_pop at cycle 5, IDLE at cycle 6.
REQ-025 Count=5, continuous load_req -> grant for 8 cycles, starve_cnt=8, then store issues despite load_req.
REQ-026 Count=24 with load_req -> no grant; store issues immediately.
REQ-027 Count=3 and i_fence -> o_stall_commit=1; three pops; o_fence_done pulses once, the cycle after count reaches 0.
REQ-028 rst asserted in WAIT -> outputs 0 at once; no pop; after release with head valid, the same address reissues.
REQ-029 Count=31 -> o_stall_commit=1; count=30 -> 0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core types: address/data words and the store-drain FSM states.
package mips_core_pkg;

  typedef logic [31:0] Address;
  typedef logic [31:0] Data;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/store_buffer_drain_ctrl.sv
// Drains committed stores into the D-cache, arbitrating against load misses
// for the shared write/fill port and handling full-drain fences.
module store_buffer_drain_ctrl
  import mips_core_pkg::*;
#(
  parameter int CAPACITY   = 32,
  parameter int HIGH_WM    = 24,
  parameter int STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(CAPACITY+1)-1:0] i_sb_count,
  input  logic                          i_sb_head_valid,
  input  Address                        i_sb_head_addr,
  input  Data                           i_sb_head_data,
  output logic                          o_sb_pop,
  input  logic                          i_load_req,
  output logic                          o_load_grant,
  output logic                          o_dc_wr_valid,
  output Address                        o_dc_wr_addr,
  output Data                           o_dc_wr_data,
  input  logic                          i_dc_wr_ready,
  input  logic                          i_dc_wr_done,
  input  logic                          i_fence,
  output logic                          o_fence_done,
  output logic                          o_stall_commit
);

  localparam int CW = $clog2(CAPACITY + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  drain_state_t   state, state_nxt;
  logic           fence_active;
  logic           fence_done_q;
  logic [SW-1:0]  starve_cnt;
  Address         addr_q;
  Data            data_q;
  logic           urgent;
  logic           sb_empty;
  logic           fence_pend;
  logic           latch_head;

  always_comb begin
    urgent     = (i_sb_count >= CW'(HIGH_WM)) || fence_active ||
                 (starve_cnt == SW'(STARVE_MAX));
    sb_empty   = (state == IDLE) && !i_sb_head_valid && (i_sb_count == '0);
    fence_pend = fence_active || i_fence;
  end

  always_comb begin
    state_nxt     = state;
    latch_head    = 1'b0;
    o_load_grant  = 1'b0;
    o_dc_wr_valid = 1'b0;
    o_sb_pop      = 1'b0;
    case (state)
      IDLE: begin
        // A load wins the port unless a ready store has become urgent.
        o_load_grant = i_load_req && !(i_sb_head_valid && urgent);
        if (i_sb_head_valid && (!i_load_req || urgent)) begin
          state_nxt  = ISSUE;
          latch_head = 1'b1;
        end
      end
      ISSUE: begin
        o_dc_wr_valid = 1'b1;
        if (i_dc_wr_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_dc_wr_done) begin
          o_sb_pop  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (latch_head) begin
      addr_q <= i_sb_head_addr;
      data_q <= i_sb_head_data;
    end
  end

  // Counts lost arbitrations while a store waits; saturates so it stays urgent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (o_sb_pop) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && i_sb_head_valid && o_load_grant &&
                 (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // A fence stays pending until the buffer is empty; repeats are absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fence_active <= 1'b0;
      fence_done_q <= 1'b0;
    end else begin
      fence_active <= fence_pend && !sb_empty;
      fence_done_q <= fence_pend && sb_empty;
    end
  end

  assign o_fence_done   = fence_done_q;
  assign o_dc_wr_addr   = addr_q;
  assign o_dc_wr_data   = data_q;
  assign o_stall_commit = !rst &&
                          ((i_sb_count >= CW'(CAPACITY - 1)) || fence_active);

endmodule
